// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle shared by the round-robin bus arbiter and its requesters.
// master: arbiter side (drives grants); slave: requester/slave side (drives req, resp_valid).
interface rr_bus_arbiter_if #(
    parameter int NREQ = 8,
    parameter int IDW  = 3
);
    logic [NREQ-1:0] req;
    logic            resp_valid;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic            timeout_err;
    logic [IDW-1:0]  last_id;

    modport master (
        input  req, resp_valid,
        output gnt, gnt_id, gnt_valid, timeout_err, last_id
    );

    modport slave (
        output req, resp_valid,
        input  gnt, gnt_id, gnt_valid, timeout_err, last_id
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the single core bus port; grant appears 1 cycle after req, back-to-back on resp_valid.
// A grant is held until resp_valid, requester abort or watchdog expiry; requests arriving while busy wait for the next arbitration point.
module rr_bus_arbiter #(
    parameter int NREQ = 8,
    parameter int IDW  = 3,
    parameter int TOW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_bus_arbiter_if.master bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Value held by the counter during the last allowed BUSY cycle (2^TOW-1 cycles in total).
    localparam logic [TOW-1:0] CNT_LAST = {{(TOW-1){1'b1}}, 1'b0};
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  r_last_id;
    logic [TOW-1:0]  r_cnt;

    state_t          w_state_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [IDW-1:0]  w_gnt_id_nxt;
    logic [IDW-1:0]  w_last_id_nxt;
    logic [TOW-1:0]  w_cnt_nxt;
    logic            w_tout;

    logic [IDW-1:0]  w_ptr;
    logic [NREQ-1:0] w_req_m;
    logic [IDW-1:0]  w_win_id;
    logic            w_win_vld;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // In the completion cycle the pointer is already the served id and its request is masked out.
    assign w_ptr   = (r_state == BUSY) ? r_gnt_id : r_last_id;
    assign w_req_m = (r_state == BUSY) ? (bus.req & ~r_gnt) : bus.req;

    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_win_vld && w_req_m[wrap_idx(w_ptr, i)]) begin
                w_win_vld = 1'b1;
                w_win_id  = wrap_idx(w_ptr, i);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_id_nxt = r_last_id;
        w_cnt_nxt     = r_cnt;
        w_tout        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt  = BUSY;
                    w_gnt_nxt    = ONE_HOT0 << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                    w_cnt_nxt    = '0;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt + TOW'(1);
                if (bus.resp_valid) begin
                    w_last_id_nxt = r_gnt_id;
                    w_cnt_nxt     = '0;
                    if (w_win_vld) begin
                        w_gnt_nxt    = ONE_HOT0 << w_win_id;
                        w_gnt_id_nxt = w_win_id;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                    end
                end else if (!bus.req[r_gnt_id] || (r_cnt == CNT_LAST)) begin
                    // Abort outranks the watchdog, so the error only fires while the request is still held.
                    w_tout        = bus.req[r_gnt_id];
                    w_last_id_nxt = r_gnt_id;
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = '0;
                    w_cnt_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_last_id <= IDW'(NREQ - 1);
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last_id <= w_last_id_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.gnt_id      = r_gnt_id;
    assign bus.gnt_valid   = |r_gnt;
    assign bus.timeout_err = w_tout;
    assign bus.last_id     = r_last_id;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (NREQ=8, TOW=4): arbitration order, wrap, abort, watchdog, async reset.
module tb_rr_bus_arbiter;
    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    rr_bus_arbiter_if #(.NREQ(8), .IDW(3)) bus ();

    rr_bus_arbiter #(.NREQ(8), .IDW(3), .TOW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic [7:0] g, input logic [2:0] id);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(id));
        chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(g != 8'h00));
    endtask

    initial begin
        rst            = 1'b0;
        bus.req        = 8'h00;
        bus.resp_valid = 1'b0;

        // 1. reset state, idle hold, first grant latency, served-bit masking
        #2 rst = 1'b1;
        #1;
        chk_g("reset", 8'h00, 3'd0);
        chk("reset.timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("reset.last_id", 32'(bus.last_id), 32'd7);
        #9 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_g("idle", 8'h00, 3'd0);
        end
        bus.resp_valid = 1'b1;
        step();
        bus.resp_valid = 1'b0;
        chk_g("idle_resp", 8'h00, 3'd0);
        chk("idle_resp.last_id", 32'(bus.last_id), 32'd7);
        bus.req = 8'h01;
        #1;
        chk_g("req0_same_cycle", 8'h00, 3'd0);
        step();
        chk_g("req0_grant", 8'h01, 3'd0);
        bus.resp_valid = 1'b1;
        step();
        bus.resp_valid = 1'b0;
        bus.req        = 8'h00;
        chk_g("req0_done", 8'h00, 3'd0);
        chk("req0_done.last_id", 32'(bus.last_id), 32'd0);

        // 2. all requesting, completion every 3rd cycle, wrap-around
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        bus.req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            chk_g($sformatf("rr%0d.c1", k), 8'h01 << (k % 8), 3'(k % 8));
            step();
            chk_g($sformatf("rr%0d.c2", k), 8'h01 << (k % 8), 3'(k % 8));
            step();
            chk_g($sformatf("rr%0d.c3", k), 8'h01 << (k % 8), 3'(k % 8));
            bus.resp_valid = 1'b1;
            step();
            bus.resp_valid = 1'b0;
        end
        chk_g("rr_after", 8'h02, 3'd1);
        chk("rr_after.last_id", 32'(bus.last_id), 32'd0);
        bus.req = 8'h00;
        step();
        chk_g("rr_abort", 8'h00, 3'd0);
        chk("rr_abort.last_id", 32'(bus.last_id), 32'd1);

        // 3. pointer at 2, requesters 1 and 7
        bus.req = 8'h04;
        step();
        chk_g("ptr_setup", 8'h04, 3'd2);
        bus.req        = 8'h00;
        bus.resp_valid = 1'b1;
        step();
        bus.resp_valid = 1'b0;
        chk("ptr_setup.last_id", 32'(bus.last_id), 32'd2);
        bus.req = 8'h82;
        step();
        chk_g("ptr_scan", 8'h80, 3'd7);
        bus.resp_valid = 1'b1;
        step();
        bus.resp_valid = 1'b0;
        chk_g("ptr_next", 8'h02, 3'd1);
        chk("ptr_next.last_id", 32'(bus.last_id), 32'd7);
        bus.req = 8'h00;
        step();
        chk_g("ptr_drop", 8'h00, 3'd0);

        // 4. abort by dropping the granted request
        bus.req = 8'h10;
        step();
        chk_g("abort_grant", 8'h10, 3'd4);
        step();
        chk_g("abort_hold", 8'h10, 3'd4);
        bus.req = 8'h00;
        step();
        chk_g("abort", 8'h00, 3'd0);
        chk("abort.timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("abort.last_id", 32'(bus.last_id), 32'd4);
        step();
        chk_g("abort_idle", 8'h00, 3'd0);

        // 5a. watchdog expiry on the 15th BUSY cycle
        bus.req = 8'h20;
        step();
        for (int c = 1; c < 15; c++) begin
            chk_g($sformatf("wd_c%0d", c), 8'h20, 3'd5);
            chk($sformatf("wd_c%0d.timeout_err", c), 32'(bus.timeout_err), 32'd0);
            step();
        end
        chk_g("wd_c15", 8'h20, 3'd5);
        chk("wd_c15.timeout_err", 32'(bus.timeout_err), 32'd1);
        step();
        bus.req = 8'h00;
        chk_g("wd_after", 8'h00, 3'd0);
        chk("wd_after.timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("wd_after.last_id", 32'(bus.last_id), 32'd5);

        // 5b. completion in the expiry cycle wins over the watchdog
        bus.req = 8'h40;
        step();
        for (int c = 1; c < 15; c++) begin
            chk($sformatf("wdr_c%0d.timeout_err", c), 32'(bus.timeout_err), 32'd0);
            step();
        end
        chk_g("wdr_c15", 8'h40, 3'd6);
        bus.resp_valid = 1'b1;
        #1;
        chk("wdr_c15.timeout_err", 32'(bus.timeout_err), 32'd0);
        step();
        bus.resp_valid = 1'b0;
        bus.req        = 8'h00;
        chk_g("wdr_after", 8'h00, 3'd0);
        chk("wdr_after.timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("wdr_after.last_id", 32'(bus.last_id), 32'd6);

        // 6. asynchronous reset mid-transaction
        bus.req = 8'h88;
        step();
        chk_g("arst_grant", 8'h80, 3'd7);
        #3 rst = 1'b1;
        #1;
        chk_g("arst_mid", 8'h00, 3'd0);
        chk("arst_mid.last_id", 32'(bus.last_id), 32'd7);
        rst = 1'b0;
        step();
        chk_g("arst_regrant", 8'h08, 3'd3);
        bus.req = 8'h00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
